mux_compare_tester: RTL and testbench

Self-checking stimulus and compare engine for characterising a generated mux against its standard-cell equivalent on silicon. It drives a shared data/select vector into both muxes and waits a programmable settle time. It then samples both outputs, checks each against an internally computed expected value, and keeps separate saturating error counts. It sits between the pad ring and the two mux instances under test, so one start pulse runs a full exhaustive or pseudo-random sweep.

---
 rtl/mux_compare_tester.sv | 185 ++++++++++++++++++
 tb/tb_mux_compare_tester.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_compare_tester.sv
// mux_compare_tester
//   Drives one data/select vector into a generated mux and into its
//   standard-cell equivalent. After a programmable settle time it compares
//   both outputs against the expected value and keeps a saturating error
//   count for each mux. One start pulse runs an exhaustive or LFSR sweep.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        run control (abort wins over start)
//   mode                0 = exhaustive, 1 = random (sampled on start)
//   num_vectors         random-mode vector count (sampled on start)
//   stim_data/sel/selb  stimulus to both muxes; selb is the registered inverse of sel
//   ref_z, dut_z        outputs of the standard-cell mux and the generated mux
//   busy, done, pass    run status; pass is valid while done
//   dut/ref_err_count   saturating mismatch counts
//   first_fail_vec      {sel,data} of the first dut mismatch, 0 if none
module mux_compare_tester #(
  parameter int unsigned SEL_BITS      = 2,
  parameter int unsigned COUNT_W       = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            mode,
  input  logic [COUNT_W-1:0]              num_vectors,
  output logic [2**SEL_BITS-1:0]          stim_data,
  output logic [SEL_BITS-1:0]             stim_sel,
  output logic [SEL_BITS-1:0]             stim_selb,
  input  logic                            ref_z,
  input  logic                            dut_z,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [COUNT_W-1:0]              dut_err_count,
  output logic [COUNT_W-1:0]              ref_err_count,
  output logic [2**SEL_BITS+SEL_BITS-1:0] first_fail_vec
);

  localparam int unsigned NIN = 2**SEL_BITS;
  localparam int unsigned W   = NIN + SEL_BITS;
  localparam logic [7:0]   SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [W-1:0] SEED_VEC    = LFSR_SEED[W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_vec;
  logic [SEL_BITS-1:0] r_selb;
  logic [15:0]        r_lfsr;
  logic [7:0]         r_settle;
  logic               r_mode;
  logic [COUNT_W-1:0] r_num_vec;
  logic [COUNT_W-1:0] r_vec_cnt;
  logic [COUNT_W-1:0] r_dut_err;
  logic [COUNT_W-1:0] r_ref_err;
  logic [W-1:0]       r_ffv;
  logic               r_fail_seen;

  logic               w_load;
  logic               w_advance;
  logic               w_compare;
  logic               w_last;
  logic               w_exp;
  logic [15:0]        w_lfsr_next;
  logic [W-1:0]       w_vec_start;
  logic [W-1:0]       w_vec_nxt;
  logic [COUNT_W-1:0] w_vec_cnt_inc;
  logic [NIN-1:0]     w_data;
  logic [SEL_BITS-1:0] w_sel;

  assign w_data        = r_vec[NIN-1:0];
  assign w_sel         = r_vec[W-1:NIN];
  assign w_exp         = w_data[w_sel];
  assign w_vec_cnt_inc = r_vec_cnt + 1'b1;
  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
  assign w_lfsr_next   = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_vec_start   = mode ? SEED_VEC : '0;
  assign w_vec_nxt     = w_load ? w_vec_start
                       : (r_mode ? w_lfsr_next[W-1:0] : r_vec + 1'b1);
  assign w_last        = r_mode ? (w_vec_cnt_inc == r_num_vec) : (r_vec == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_compare   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (mode && num_vectors == '0) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (r_settle == '0) w_state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        busy      = 1'b1;
        w_compare = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // abort overrides every action so stimulus and counts freeze in place
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      w_compare   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec       <= '0;
      r_selb      <= '1;
      r_lfsr      <= LFSR_SEED;
      r_settle    <= '0;
      r_mode      <= 1'b0;
      r_num_vec   <= '0;
      r_vec_cnt   <= '0;
      r_dut_err   <= '0;
      r_ref_err   <= '0;
      r_ffv       <= '0;
      r_fail_seen <= 1'b0;
    end else begin
      if (w_load) begin
        r_mode      <= mode;
        r_num_vec   <= num_vectors;
        r_vec_cnt   <= '0;
        r_dut_err   <= '0;
        r_ref_err   <= '0;
        r_ffv       <= '0;
        r_fail_seen <= 1'b0;
        if (mode) r_lfsr <= LFSR_SEED;
      end
      if (w_advance && r_mode) r_lfsr <= w_lfsr_next;
      if (w_load || w_advance) begin
        r_vec    <= w_vec_nxt;
        r_selb   <= ~w_vec_nxt[W-1:NIN];
        r_settle <= SETTLE_LOAD;
      end else if (r_state == S_SETTLE && r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end
      if (w_compare) begin
        r_vec_cnt <= w_vec_cnt_inc;
        if (dut_z != w_exp) begin
          if (r_dut_err != '1) r_dut_err <= r_dut_err + 1'b1;
          if (!r_fail_seen) begin
            r_fail_seen <= 1'b1;
            r_ffv       <= r_vec;
          end
        end
        if (ref_z != w_exp && r_ref_err != '1) r_ref_err <= r_ref_err + 1'b1;
      end
    end
  end

  assign stim_data      = w_data;
  assign stim_sel       = w_sel;
  assign stim_selb      = r_selb;
  assign dut_err_count  = r_dut_err;
  assign ref_err_count  = r_ref_err;
  assign first_fail_vec = r_ffv;
  assign pass           = (r_state == S_DONE) && (r_dut_err == '0) && (r_ref_err == '0);

endmodule

// File: tb/tb_mux_compare_tester.sv
module tb_mux_compare_tester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [3:0]  stim_data;
  logic [1:0]  stim_sel;
  logic [1:0]  stim_selb;
  logic        ref_z;
  logic        dut_z;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] dut_err_count;
  logic [15:0] ref_err_count;
  logic [5:0]  first_fail_vec;

  // second instance with narrow counters for saturation and reset checks
  logic        rst_n4 = 1'b0;
  logic        start4 = 1'b0;
  logic [3:0]  stim_data4;
  logic [1:0]  stim_sel4;
  logic [1:0]  stim_selb4;
  logic        ref_z4;
  logic        dut_z4;
  logic        busy4;
  logic        done4;
  logic        pass4;
  logic [3:0]  dut_err_count4;
  logic [3:0]  ref_err_count4;
  logic [5:0]  first_fail_vec4;

  // per-vector output flip tables for the two mux stand-ins
  logic [63:0] dut_flip = '0;
  logic [63:0] ref_flip = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mux_compare_tester #(.SEL_BITS(2), .COUNT_W(16), .SETTLE_CYCLES(2), .LFSR_SEED(16'hACE1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .num_vectors(num_vectors), .stim_data(stim_data), .stim_sel(stim_sel),
    .stim_selb(stim_selb), .ref_z(ref_z), .dut_z(dut_z), .busy(busy), .done(done),
    .pass(pass), .dut_err_count(dut_err_count), .ref_err_count(ref_err_count),
    .first_fail_vec(first_fail_vec)
  );

  mux_compare_tester #(.SEL_BITS(2), .COUNT_W(4), .SETTLE_CYCLES(2), .LFSR_SEED(16'hACE1)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .abort(1'b0), .mode(1'b0),
    .num_vectors(4'd0), .stim_data(stim_data4), .stim_sel(stim_sel4),
    .stim_selb(stim_selb4), .ref_z(ref_z4), .dut_z(dut_z4), .busy(busy4), .done(done4),
    .pass(pass4), .dut_err_count(dut_err_count4), .ref_err_count(ref_err_count4),
    .first_fail_vec(first_fail_vec4)
  );

  function automatic int unsigned mux_out(input int unsigned v);
    return ((v % 16) >> (v / 16)) % 2;
  endfunction

  function automatic int unsigned lfsr_step(input int unsigned s);
    int unsigned b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return ((s >> 1) | (b << 15)) & 16'hFFFF;
  endfunction

  always_comb begin
    dut_z  = 1'(mux_out({stim_sel, stim_data})) ^ dut_flip[{stim_sel, stim_data}];
    ref_z  = 1'(mux_out({stim_sel, stim_data})) ^ ref_flip[{stim_sel, stim_data}];
    dut_z4 = ~1'(mux_out({stim_sel4, stim_data4}));
    ref_z4 = 1'(mux_out({stim_sel4, stim_data4}));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one sweep on u_dut; must be entered right after a falling edge.
  task automatic run_sweep(input logic md, input int unsigned nv, input string tag);
    int unsigned vecs[$];
    int unsigned s;
    int unsigned n;
    int unsigned e_dut;
    int unsigned e_ref;
    int unsigned ffv;
    bit          seen;
    e_dut = 0; e_ref = 0; ffv = 0; seen = 0;
    if (md) begin
      s = 16'hACE1;
      for (int unsigned i = 0; i < nv; i++) begin
        vecs.push_back(s % 64);
        s = lfsr_step(s);
      end
    end else begin
      for (int unsigned v = 0; v < 64; v++) vecs.push_back(v);
    end
    n = vecs.size();
    foreach (vecs[i]) begin
      if (dut_flip[vecs[i]]) begin
        if (e_dut < 65535) e_dut++;
        if (!seen) begin
          seen = 1;
          ffv  = vecs[i];
        end
      end
      if (ref_flip[vecs[i]] && e_ref < 65535) e_ref++;
    end

    start = 1'b1;
    mode  = md;
    num_vectors = 16'(nv);
    @(negedge clk);
    start = 1'b0;
    for (int unsigned k = 0; k < 3 * n; k++) begin
      check({tag, "_busy_done"}, {busy, done}, 2'b10);
      check({tag, "_stim"}, {stim_selb, stim_sel, stim_data},
            {~2'(vecs[k / 3] / 16), 6'(vecs[k / 3])});
      @(negedge clk);
    end
    check({tag, "_end_busy_done"}, {busy, done}, 2'b01);
    check({tag, "_dut_err"}, dut_err_count, e_dut);
    check({tag, "_ref_err"}, ref_err_count, e_ref);
    check({tag, "_ffv"}, first_fail_vec, ffv);
    check({tag, "_pass"}, pass, (e_dut == 0 && e_ref == 0) ? 1 : 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    rst_n4 = 1'b1;
    @(negedge clk);
    check("rst_status", {busy, done, pass}, 3'b000);
    check("rst_counts", {dut_err_count, ref_err_count}, 32'h0);
    check("rst_stim", {stim_selb, stim_sel, stim_data, first_fail_vec}, {2'b11, 6'h00, 6'h00});

    // ideal muxes, exhaustive
    run_sweep(1'b0, 0, "exh_ideal");

    // generated mux stuck at 0
    for (int unsigned v = 0; v < 64; v++) dut_flip[v] = 1'(mux_out(v));
    run_sweep(1'b0, 0, "exh_stuck0");
    check("stuck0_ffv_const", first_fail_vec, 6'h01);
    check("stuck0_cnt_const", dut_err_count, 32);

    // random mode, ideal
    dut_flip = '0;
    run_sweep(1'b1, 100, "rnd100");
    run_sweep(1'b1, 0, "rnd0");

    // random fault tables, random modes and lengths
    repeat (4) begin
      dut_flip = {$urandom, $urandom} & {$urandom, $urandom};
      ref_flip = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      run_sweep(1'($urandom_range(0, 1)), $urandom_range(1, 50), "rnd_fault");
    end

    // abort during an exhaustive run with the standard-cell mux inverted
    dut_flip = '0;
    ref_flip = '1;
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_ref_err", ref_err_count, 50 / 3);
    start = 1'b1;
    @(negedge clk);
    check("abort_beats_start", {busy, done}, 2'b00);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_hold_ref", ref_err_count, 50 / 3);
    check("abort_hold_stim", {stim_sel, stim_data}, 6'(50 / 3));
    check("abort_hold_idle", {busy, done, pass}, 3'b000);
    run_sweep(1'b0, 0, "rerun");

    // narrow counters saturate
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (192) @(negedge clk);
    check("sat_done", {busy4, done4, pass4}, 3'b010);
    check("sat_dut_err", dut_err_count4, 15);
    check("sat_ref_err", ref_err_count4, 0);

    // asynchronous reset mid-run
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_busy", busy4, 1'b1);
    #2 rst_n4 = 1'b0;
    #1;
    check("arst_status", {busy4, done4, pass4}, 3'b000);
    check("arst_counts", {dut_err_count4, ref_err_count4, first_fail_vec4}, 14'h0);
    check("arst_stim", {stim_selb4, stim_sel4, stim_data4}, {2'b11, 6'h00});
    @(negedge clk);
    rst_n4 = 1'b1;
    @(negedge clk);
    check("arst_idle", {busy4, done4}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // busy and done must never overlap on either instance
  always @(negedge clk) begin
    if (rst_n && busy && done) check("busy_and_done", 1'b1, 1'b0);
    if (rst_n4 && busy4 && done4) check("busy_and_done4", 1'b1, 1'b0);
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
